// File: rtl/sd_pic_sched_if.sv
// Sector request handshake between the picture scheduler (master) and the CMD17 read engine (slave).
interface sd_pic_sched_if;
  logic        rd_req;
  logic [31:0] rd_sec;
  logic        rd_ack;
  logic        rd_done;

  modport master (output rd_req, output rd_sec, input rd_ack, input rd_done);
  modport slave  (input rd_req, input rd_sec, output rd_ack, output rd_done);
endinterface

// File: rtl/sd_pic_sched.sv
// Picture loader: issues one SD sector read at a time from a selected base, throttled by fifo_afull,
// with per-sector timeout/retry. Define SD_SCHED_LOOP_EN for continuous picture replay.
module sd_pic_sched #(
  parameter logic [11:0] SEC_LEN   = 12'd3072,
  parameter logic [31:0] BASE0     = 32'd16448,
  parameter logic [31:0] BASE1     = 32'd19520,
  parameter logic [31:0] BASE2     = 32'd39928,
  parameter logic [31:0] BASE3     = 32'd43000,
  parameter logic [7:0]  GAP_CYC   = 8'd16,
  parameter logic [21:0] TMO_CYC   = 22'd4000000,
  parameter logic [1:0]  MAX_RETRY = 2'd3
) (
  input  logic           SD_clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     pic_sel,
  input  logic           abort,
  input  logic           fifo_afull,
  sd_pic_sched_if.master rd,
  output logic           busy,
  output logic [11:0]    sec_cnt,
  output logic           frame_done,
  output logic           err
);

  typedef enum logic [2:0] {S_IDLE, S_SPACE, S_REQ, S_WAIT, S_GAP, S_DONE, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [31:0] rd_sec_q;
  logic [11:0] sec_cnt_q;
  logic [1:0]  retry_q;
  logic [21:0] timer_q;
  logic [7:0]  gap_q;
  logic        abort_q;
`ifdef SD_SCHED_LOOP_EN
  logic [1:0]  pic_q;
  logic        fdone_pulse_q;
`endif

  function automatic logic [31:0] base_of(input logic [1:0] sel);
    case (sel)
      2'd0:    base_of = BASE0;
      2'd1:    base_of = BASE1;
      2'd2:    base_of = BASE2;
      default: base_of = BASE3;
    endcase
  endfunction

  logic can_start, sec_ok, tmo, gap_end, frame_full, abort_any, retry_ok;

  assign can_start  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  // An ack and done in the same cycle count the sector directly from REQ.
  assign sec_ok     = (state_q == S_REQ && rd.rd_ack && rd.rd_done) || (state_q == S_WAIT && rd.rd_done);
  assign tmo        = (state_q == S_WAIT) && !rd.rd_done && (timer_q == TMO_CYC - 22'd1);
  assign gap_end    = (state_q == S_GAP) && (gap_q == GAP_CYC - 8'd1);
  assign frame_full = (sec_cnt_q == SEC_LEN);
  assign abort_any  = abort_q || abort;
  assign retry_ok   = (retry_q < MAX_RETRY);

  always_ff @(posedge SD_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_SPACE;
      S_SPACE: begin
        if (abort)            state_d = S_IDLE;
        else if (!fifo_afull) state_d = S_REQ;
      end
      S_REQ: begin
        if (rd.rd_ack)  state_d = rd.rd_done ? S_GAP : S_WAIT;
        else if (abort) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (rd.rd_done) state_d = S_GAP;
        else if (tmo)   state_d = retry_ok ? S_GAP : S_ERR;
      end
      S_GAP: begin
        if (gap_end) begin
          if (abort_any)       state_d = S_IDLE;
`ifdef SD_SCHED_LOOP_EN
          else if (frame_full) state_d = S_SPACE;
`else
          else if (frame_full) state_d = S_DONE;
`endif
          else                 state_d = S_SPACE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SD_clk) begin
    if (rst) begin
      rd_sec_q  <= '0;
      sec_cnt_q <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      abort_q   <= 1'b0;
`ifdef SD_SCHED_LOOP_EN
      pic_q         <= '0;
      fdone_pulse_q <= 1'b0;
`endif
    end else begin
      timer_q <= (state_q == S_WAIT) ? timer_q + 22'd1 : '0;
      gap_q   <= (state_q == S_GAP) ? gap_q + 8'd1 : '0;
      if (can_start) begin
        rd_sec_q  <= base_of(pic_sel);
        sec_cnt_q <= '0;
        retry_q   <= '0;
        abort_q   <= 1'b0;
      end
      if (sec_ok) begin
        if (!frame_full) sec_cnt_q <= sec_cnt_q + 12'd1;
        rd_sec_q <= rd_sec_q + 32'd1;
        retry_q  <= '0;
      end else if (tmo && retry_ok) begin
        retry_q <= retry_q + 2'd1;
      end
      // Abort after the request is accepted waits for the sector to finish.
      if (state_q == S_WAIT || state_q == S_GAP || (state_q == S_REQ && rd.rd_ack))
        abort_q <= abort_q | abort;
`ifdef SD_SCHED_LOOP_EN
      fdone_pulse_q <= 1'b0;
      if (can_start) pic_q <= pic_sel;
      if (gap_end && !abort_any && frame_full) begin
        rd_sec_q      <= base_of(pic_q);
        sec_cnt_q     <= '0;
        fdone_pulse_q <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    busy = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    err  = (state_q == S_ERR);
`ifdef SD_SCHED_LOOP_EN
    frame_done = fdone_pulse_q;
`else
    frame_done = (state_q == S_DONE);
`endif
  end

  assign rd.rd_req = (state_q == S_REQ);
  assign rd.rd_sec = rd_sec_q;
  assign sec_cnt   = sec_cnt_q;

endmodule

// File: tb/tb_sd_pic_sched.sv
// Randomised bench for sd_pic_sched: the bench plays the SD engine and predicts addresses,
// counts and request timing from base+index arithmetic and gap/timeout cycle budgets.
module tb_sd_pic_sched;
  localparam logic [11:0] SEC_LEN = 12'd4;
  localparam int GAP = 4;
  localparam int TMO = 100;

  logic        SD_clk = 1'b0;
  logic        rst, start, abort, fifo_afull;
  logic [1:0]  pic_sel;
  logic        busy, frame_done, err;
  logic [11:0] sec_cnt;

  sd_pic_sched_if rd_if ();

  sd_pic_sched #(
    .SEC_LEN(SEC_LEN), .GAP_CYC(8'd4), .TMO_CYC(22'd100)
  ) dut (
    .SD_clk(SD_clk), .rst(rst), .start(start), .pic_sel(pic_sel), .abort(abort),
    .fifo_afull(fifo_afull), .rd(rd_if), .busy(busy), .sec_cnt(sec_cnt),
    .frame_done(frame_done), .err(err)
  );

  always #5 SD_clk = ~SD_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_sec;
  logic [11:0] exp_cnt;
  logic [31:0] cur_base;
  int          nxt_wait;

  function automatic logic [31:0] pic_base(input int p);
    case (p)
      0:       pic_base = 32'd16448;
      1:       pic_base = 32'd19520;
      2:       pic_base = 32'd39928;
      default: pic_base = 32'd43000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge SD_clk);
    #1;
  endtask

  task automatic do_start(input int p);
    pic_sel = 2'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    cur_base = pic_base(p);
    exp_sec  = cur_base;
    exp_cnt  = '0;
    nxt_wait = 1;
    chk("start_busy", busy, 1);
    chk("start_err", err, 0);
    chk("start_fdone", frame_done, 0);
    chk("start_cnt", sec_cnt, 0);
  endtask

  // mode: 0 done after random delay, 1 withhold done, 2 done with ack, 3 done on timeout cycle
  task automatic serve(input int afull_k, input int mode, input bit abort_wait);
    int w, d, dd, ew;
    w = 0;
    while (!rd_if.rd_req && w < 1000) begin
      fifo_afull = (w < afull_k);
      tick();
      w++;
    end
    fifo_afull = 1'b0;
    ew = (afull_k + 1 > nxt_wait) ? afull_k + 1 : nxt_wait;
    chk("req_wait", w, ew);
    if (!rd_if.rd_req) return;
    chk("rd_sec", rd_if.rd_sec, exp_sec);
    d = $urandom_range(0, 3);
    repeat (d) tick();
    chk("req_hold", rd_if.rd_req, 1);
    rd_if.rd_ack = 1'b1;
    if (mode == 2) rd_if.rd_done = 1'b1;
    tick();
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_done = 1'b0;
    chk("req_drop", rd_if.rd_req, 0);
    if (mode == 1) begin
      nxt_wait = TMO + GAP + 1;
      return;
    end
    if (abort_wait) abort = 1'b1;
    if (mode != 2) begin
      dd = (mode == 3) ? TMO - 1 : $urandom_range(0, 60);
      repeat (dd) tick();
      rd_if.rd_done = 1'b1;
      tick();
      rd_if.rd_done = 1'b0;
    end
    if (exp_cnt < SEC_LEN) exp_cnt++;
    exp_sec++;
    chk("sec_cnt", sec_cnt, exp_cnt);
    nxt_wait = GAP + 1;
  endtask

  task automatic finish_pic;
    repeat (GAP) tick();
`ifdef SD_SCHED_LOOP_EN
    chk("loop_fdone", frame_done, 1);
    chk("loop_busy", busy, 1);
    chk("loop_cnt", sec_cnt, 0);
    exp_cnt  = '0;
    exp_sec  = cur_base;
    nxt_wait = 1;
    serve(0, 0, 1'b1);
    repeat (GAP) tick();
    chk("loop_abort_busy", busy, 0);
    abort = 1'b0;
`else
    chk("done_fdone", frame_done, 1);
    chk("done_busy", busy, 0);
    chk("done_err", err, 0);
    chk("done_cnt", sec_cnt, exp_cnt);
    chk("done_req", rd_if.rd_req, 0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_afull = 1'b0; pic_sel = 2'd0;
    rd_if.rd_ack = 1'b0; rd_if.rd_done = 1'b0;
    repeat (3) tick();
    chk("rst_req", rd_if.rd_req, 0);
    chk("rst_sec", rd_if.rd_sec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", sec_cnt, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // Full picture 3 load
    do_start(3);
    repeat (int'(SEC_LEN)) serve(0, 0, 1'b0);
    finish_pic();

    // Almost-full hold after the first sector, then done exactly on the timeout cycle
    do_start(0);
    serve(0, 0, 1'b0);
    serve(30, 0, 1'b0);
    serve(0, 2, 1'b0);
    serve(0, 3, 1'b0);
    finish_pic();

    // Three retries of the same sector, fourth timeout errors out
    do_start(2);
    repeat (4) serve(0, 1, 1'b0);
    repeat (TMO - 1) tick();
    chk("tmo_busy_before", busy, 1);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_req", rd_if.rd_req, 0);

    // Abort during sector 2: sector still counted, then idle
    do_start(1);
    serve(0, 0, 1'b0);
    serve(0, 0, 1'b0);
    serve(0, 0, 1'b1);
    repeat (GAP) tick();
    chk("abort_busy", busy, 0);
    chk("abort_cnt", sec_cnt, 3);
    chk("abort_fdone", frame_done, 0);
    abort = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      tick();
      if (rd_if.rd_req) quiet = 1'b0;
    end
    chk("abort_quiet", quiet, 1);

    // Start while busy is ignored; reset mid-wait clears everything
    do_start(0);
    serve(0, 0, 1'b0);
    serve(0, 1, 1'b0);
    repeat (5) tick();
    pic_sel = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_sec", rd_if.rd_sec, exp_sec);
    chk("busy_start_cnt", sec_cnt, exp_cnt);
    chk("busy_start_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mrst_req", rd_if.rd_req, 0);
    chk("mrst_sec", rd_if.rd_sec, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", sec_cnt, 0);
    chk("mrst_fdone", frame_done, 0);
    chk("mrst_err", err, 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("mrst_idle_req", rd_if.rd_req, 0);
    chk("mrst_idle_busy", busy, 0);

    // Randomised pictures
    for (int p = 0; p < 6; p++) begin
      do_start(int'($urandom_range(0, 3)));
      for (int s = 0; s < int'(SEC_LEN); s++) begin
        int k, m, r;
        k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
        if ($urandom_range(0, 5) == 0) begin
          serve(k, 1, 1'b0);
          k = 0;
        end
        r = $urandom_range(0, 5);
        m = (r == 0) ? 2 : (r == 1) ? 3 : 0;
        serve(k, m, 1'b0);
      end
      finish_pic();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
